// File: rtl/configurable_delay_line.sv
// Run-time selectable delay line: MAX_DEPTH stages of {data, valid} with stall,
// flush and a combinational bypass when the selected delay is zero.
module configurable_delay_line #(
  parameter int WIDTH     = 1,
  parameter int MAX_DEPTH = 2,
  localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [DW-1:0]    delay,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  logic [MAX_DEPTH-1:0][WIDTH-1:0] data;
  logic [MAX_DEPTH-1:0]            valid;
  logic [DW-1:0]                   tap;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would collapse the shift chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data  <= '0;
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (en) begin
      data[0]  <= in;
      valid[0] <= in_valid;
      for (int k = 1; k < MAX_DEPTH; k++) begin
        data[k]  <= data[k-1];
        valid[k] <= valid[k-1];
      end
    end
  end

  // Out-of-range requests saturate at the deepest physical stage.
  always_comb begin
    tap = (delay > DW'(MAX_DEPTH)) ? DW'(MAX_DEPTH) : delay;
  end

  // NOTE: outputs get a default before the tap search so no path infers a latch;
  // the default doubles as the zero-delay bypass.
  always_comb begin
    out       = in;
    out_valid = in_valid;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (tap == DW'(k + 1)) begin
        out       = data[k];
        out_valid = valid[k];
      end
    end
  end

  always_comb begin
    busy = |valid;
  end

endmodule

// File: tb/tb_configurable_delay_line.sv
// Directed bench for configurable_delay_line (WIDTH=8, MAX_DEPTH=4): reset, fixed
// delay, bypass/clamp, stall, flush and run-time delay change.
module tb_configurable_delay_line;

  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic [2:0]       delay;
  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference pipeline, advanced alongside the DUT on every clock edge.
  logic [WIDTH-1:0] m_data [MAX_DEPTH];
  logic             m_v    [MAX_DEPTH];

  configurable_delay_line #(
    .WIDTH    (WIDTH),
    .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .delay    (delay),
    .in       (din),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic e, input logic f, input logic [2:0] dl,
                       input logic [7:0] d, input logic vi);
    en       = e;
    flush    = f;
    delay    = dl;
    din      = d;
    in_valid = vi;
    #1;
  endtask

  // Update the model from the inputs about to be sampled, then cross the edge.
  task automatic advance();
    if (!rst) begin
      for (int k = 0; k < MAX_DEPTH; k++) begin
        m_data[k] = '0;
        m_v[k]    = 1'b0;
      end
    end else if (flush) begin
      for (int k = 0; k < MAX_DEPTH; k++) m_v[k] = 1'b0;
    end else if (en) begin
      for (int k = MAX_DEPTH - 1; k > 0; k--) begin
        m_data[k] = m_data[k-1];
        m_v[k]    = m_v[k-1];
      end
      m_data[0] = din;
      m_v[0]    = in_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_check(input string tag);
    int d;
    logic             exp_v;
    logic [WIDTH-1:0] exp_d;
    d = (int'(delay) > MAX_DEPTH) ? MAX_DEPTH : int'(delay);
    if (d == 0) begin
      exp_v = in_valid;
      exp_d = din;
    end else begin
      exp_v = m_v[d-1];
      exp_d = m_data[d-1];
    end
    check({tag, "_v"}, 32'(out_valid), 32'(exp_v));
    if (exp_v) check({tag, "_d"}, 32'(out), 32'(exp_d));
  endtask

  initial begin
    // Reset held for two edges with live input; everything must read zero.
    rst = 1'b0;
    drive(1, 0, 3, 8'h5A, 1); advance();
    drive(1, 0, 3, 8'h5A, 1); advance();
    drive(1, 0, 3, 8'h5A, 1);
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    drive(1, 0, 3, 8'h00, 0); advance();
    check("post_rst_out_valid", 32'(out_valid), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);
    advance();
    check("post_rst_busy2", 32'(busy), 32'h0);

    // Fixed delay of 3 with a three-sample burst.
    drive(1, 0, 3, 8'h11, 1); advance();
    drive(1, 0, 3, 8'h22, 1); advance();
    drive(1, 0, 3, 8'h33, 1); advance();
    drive(1, 0, 3, 8'h00, 0);
    check("fix_c3_v", 32'(out_valid), 32'h1);
    check("fix_c3_d", 32'(out), 32'h11);
    advance();
    check("fix_c4_v", 32'(out_valid), 32'h1);
    check("fix_c4_d", 32'(out), 32'h22);
    advance();
    check("fix_c5_v", 32'(out_valid), 32'h1);
    check("fix_c5_d", 32'(out), 32'h33);
    advance();
    check("fix_c6_v", 32'(out_valid), 32'h0);
    check("fix_c6_busy", 32'(busy), 32'h1);
    advance();
    check("fix_c7_busy", 32'(busy), 32'h0);

    // Zero delay is a combinational bypass, independent of en and flush.
    drive(0, 0, 0, 8'hA5, 1);
    check("byp_d", 32'(out), 32'hA5);
    check("byp_v", 32'(out_valid), 32'h1);
    drive(0, 1, 0, 8'h3C, 1);
    check("byp_flush_d", 32'(out), 32'h3C);
    check("byp_flush_v", 32'(out_valid), 32'h1);
    drive(0, 0, 0, 8'h00, 0);
    check("byp_idle_v", 32'(out_valid), 32'h0);
    advance();

    // delay=7 saturates at 4.
    drive(1, 0, 7, 8'h77, 1); advance();
    for (int c = 1; c <= 3; c++) begin
      drive(1, 0, 7, 8'h00, 0);
      check($sformatf("clamp_c%0d_v", c), 32'(out_valid), 32'h0);
      advance();
    end
    check("clamp_c4_v", 32'(out_valid), 32'h1);
    check("clamp_c4_d", 32'(out), 32'h77);
    advance();
    check("clamp_c5_v", 32'(out_valid), 32'h0);
    check("clamp_c5_busy", 32'(busy), 32'h0);

    // Two stall cycles push a delay-2 sample from cycle 2 to cycle 4.
    drive(1, 0, 2, 8'h01, 1); advance();
    drive(0, 0, 2, 8'hEE, 1);
    check("stall_c1_v", 32'(out_valid), 32'h0);
    advance();
    drive(0, 0, 2, 8'hEE, 1);
    check("stall_c2_v", 32'(out_valid), 32'h0);
    advance();
    drive(1, 0, 2, 8'h00, 0);
    check("stall_c3_v", 32'(out_valid), 32'h0);
    advance();
    check("stall_c4_v", 32'(out_valid), 32'h1);
    check("stall_c4_d", 32'(out), 32'h01);
    advance();
    check("stall_c5_v", 32'(out_valid), 32'h0);
    for (int c = 0; c < 4; c++) advance();
    check("stall_drained_busy", 32'(busy), 32'h0);

    // Flush beats enable and discards the concurrent input.
    drive(1, 0, 4, 8'hA1, 1); advance();
    drive(1, 0, 4, 8'hA2, 1); advance();
    drive(1, 0, 4, 8'hA3, 1); advance();
    drive(1, 1, 4, 8'hFF, 1);
    check("flush_pre_busy", 32'(busy), 32'h1);
    advance();
    drive(1, 0, 4, 8'h5C, 1);
    check("flush_c4_v", 32'(out_valid), 32'h0);
    check("flush_c4_busy", 32'(busy), 32'h0);
    advance();
    for (int c = 5; c <= 7; c++) begin
      drive(1, 0, 4, 8'h00, 0);
      check($sformatf("flush_c%0d_v", c), 32'(out_valid), 32'h0);
      advance();
    end
    check("flush_c8_v", 32'(out_valid), 32'h1);
    check("flush_c8_d", 32'(out), 32'h5C);
    advance();
    check("flush_c9_v", 32'(out_valid), 32'h0);
    check("flush_c9_busy", 32'(busy), 32'h0);

    // Shrink the delay from 4 to 2 mid-stream: 0x3 and 0x4 show, 0x1/0x2 are dropped.
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 4, 8'(c + 1), 1);
      model_check($sformatf("chg_c%0d", c));
      advance();
    end
    drive(1, 0, 2, 8'h00, 0);
    model_check("chg_c4");
    check("chg_c4_v", 32'(out_valid), 32'h1);
    check("chg_c4_d", 32'(out), 32'h03);
    advance();
    model_check("chg_c5");
    check("chg_c5_v", 32'(out_valid), 32'h1);
    check("chg_c5_d", 32'(out), 32'h04);
    advance();
    model_check("chg_c6");
    check("chg_c6_v", 32'(out_valid), 32'h0);
    advance();
    model_check("chg_c7");
    check("chg_c7_v", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/configurable_delay_line.md
# configurable_delay_line

Parametrised successor to the fixed one- and two-stage delay registers in `src/pipeline`. It is a WIDTH-bit data plus valid shift pipeline of MAX_DEPTH stages. The delay is selectable at run time (0..MAX_DEPTH), and the block adds a global stall (enable) and a flush. It aligns control and data paths whose latency differs by a configuration-dependent number of cycles, replacing ad-hoc chains of fixed delay registers.

## Interface
Parameters:
- WIDTH, default 1: data width in bits (≥1).
- MAX_DEPTH, default 2: number of physical stages (≥1).
- DW, default $clog2(MAX_DEPTH+1): width of the `delay` port (localparam, derived).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-low. Sampled on the rising edge of clk; rst=0 resets the block.
- en  input  1  advance enable. 0 = every stage holds.
- flush  input  1  synchronous clear of all valid bits.
- delay  input  DW  selected latency in cycles; values >MAX_DEPTH are clamped to MAX_DEPTH.
- in  input  WIDTH  data in.
- in_valid  input  1  qualifies `in`.
- out  output  WIDTH  data at the selected tap.
- out_valid  output  1  valid at the selected tap.
- busy  output  1  OR of all MAX_DEPTH stage valid bits.

## Operation
- State: stage[0..MAX_DEPTH-1] of {data[WIDTH], v}. stage[0] is fed from in/in_valid; stage[k] is fed from stage[k-1].
- Priority, highest first, evaluated at each rising edge:
  1. rst=0: all data ← 0, all v ← 0.
  2. flush=1: all v ← 0; data registers hold; in/in_valid on this cycle are discarded; `en` is ignored.
  3. en=1: all stages shift by one; stage[0] ← {in, in_valid}.
  4. en=0: all stages hold.
- Data registers load regardless of valid. Only `v` carries meaning; `out` is don't-care while out_valid=0.
- Effective delay d = min(delay, MAX_DEPTH).
- Output tap:
  - d=0: out=in, out_valid=in_valid. Combinational bypass, independent of en and flush.
  - d≥1: out=stage[d-1].data, out_valid=stage[d-1].v.
- Run-time change of `delay`:
  - The tap moves in the same cycle. No draining or realignment is performed.
  - Decreasing d by n: entries in stages d..old_d-1 are never presented (dropped).
  - Increasing d by n: entries already past the old tap are presented a second time, provided they are still in the pipe.
  - Upstream owns changing `delay` only when the pipe is empty (busy=0) or when loss/duplication is acceptable.
- busy covers all physical stages, not only those up to the tap.

## Timing
- Reset values: out=0 and out_valid=0 (d≥1); busy=0. With d=0, out/out_valid follow in/in_valid even during reset.
- Latency with en held at 1: a sample presented at edge t appears on out/out_valid after edge t+d-1, i.e. visible in cycle t+d. A stream is reproduced exactly, shifted by d cycles.
- Stalls: each en=0 cycle adds exactly one cycle of latency to every in-flight entry. The in/in_valid presented on a stall cycle is not captured.
- Flush: out_valid=0 and busy=0 from the cycle after the flush edge. Entries captured after flush appear normally.
- Reset during operation: behaves identically to flush, except that data is also zeroed.
- No back-pressure output exists. Upstream must stall itself in lockstep with en.

## Test plan
- Reset: hold rst=0 for 2 cycles, with WIDTH=8, MAX_DEPTH=4, delay=3. Require out=0, out_valid=0, busy=0. Release rst and drive in_valid=0: these remain 0.
- Fixed delay: WIDTH=8, MAX_DEPTH=4, delay=3, en=1. Drive in=0x11,0x22,0x33 with in_valid=1 on cycles 0-2. Require out_valid=1 with out=0x11,0x22,0x33 on cycles 3-5 and out_valid=0 on cycle 6. busy falls after 0x33 leaves stage 3 (cycle 7).
- Bypass and clamp: delay=0, in=0xA5, in_valid=1 → out=0xA5 and out_valid=1 in the same cycle. delay=7 behaves as delay=4 (single sample emerges after 4 cycles).
- Stall: delay=2, send 0x01 at cycle 0, en=0 on cycles 1-2, en=1 afterwards. Require 0x01 valid at cycle 4, not cycle 2. A sample offered on cycle 1 is not captured.
- Flush vs. enable: with 3 samples in flight (delay=4), assert flush=1 together with en=1 and in_valid=1, in=0xFF. Require out_valid=0 and busy=0 on the next cycle, and 0xFF never emerges. A sample sent 1 cycle later emerges 4 cycles after entry.
- Delay change: with delay=4 and samples 0x1..0x4 entered on consecutive cycles, switch to delay=2 one cycle after 0x4 enters. Require 0x4 emerges 2 cycles after entry, and 0x1/0x2 are dropped per the tap rule. Check out_valid and data against a reference model.
